// File: rtl/ulpi_pkg.sv
// Shared definitions for the ULPI register-access scheduler: FSM encoding,
// ULPI register map constants and parameter defaults.
package ulpi_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_BACKOFF = 2'd2,
        S_RESP    = 2'd3
    } sched_state_e;

    localparam logic [5:0] ULPI_VENDOR_ID_LO = 6'h00;
    localparam logic [5:0] ULPI_PRODUCT_ID_LO = 6'h02;
    localparam logic [5:0] ULPI_FUNC_CTRL    = 6'h04;
    localparam logic [5:0] ULPI_IFC_CTRL     = 6'h07;
    localparam logic [5:0] ULPI_OTG_CTRL     = 6'h0A;
    localparam logic [5:0] ULPI_SCRATCH      = 6'h16;

    localparam int MAX_RETRY_DEF   = 3;
    localparam int BACKOFF_CYC_DEF = 4;
    localparam int TIMEOUT_CYC_DEF = 255;

    // Bits needed to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ulpi_reg_sched_if.sv
// Request-side and ULPI-side signal bundle of the register scheduler.
// master = requesters plus PHY model; slave = the scheduler itself.
interface ulpi_reg_sched_if;
    logic       REQ0_VALID;
    logic       REQ0_RW;
    logic [5:0] REQ0_ADDR;
    logic [7:0] REQ0_WDATA;
    logic       REQ0_ACK;
    logic       REQ0_FAIL;
    logic [7:0] REQ0_RDATA;

    logic       REQ1_VALID;
    logic       REQ1_RW;
    logic [5:0] REQ1_ADDR;
    logic [7:0] REQ1_WDATA;
    logic       REQ1_ACK;
    logic       REQ1_FAIL;
    logic [7:0] REQ1_RDATA;

    logic       REG_EN;
    logic       REG_RW;
    logic [5:0] REG_ADDR;
    logic [7:0] REG_DATA_I;
    logic [7:0] REG_DATA_O;
    logic       REG_DONE;
    logic       REG_FAIL;
    logic       READY;
    logic       BUSY;

    modport master (
        output REQ0_VALID, REQ0_RW, REQ0_ADDR, REQ0_WDATA,
        output REQ1_VALID, REQ1_RW, REQ1_ADDR, REQ1_WDATA,
        output REG_DATA_O, REG_DONE, REG_FAIL, READY,
        input  REQ0_ACK, REQ0_FAIL, REQ0_RDATA,
        input  REQ1_ACK, REQ1_FAIL, REQ1_RDATA,
        input  REG_EN, REG_RW, REG_ADDR, REG_DATA_I, BUSY
    );

    modport slave (
        input  REQ0_VALID, REQ0_RW, REQ0_ADDR, REQ0_WDATA,
        input  REQ1_VALID, REQ1_RW, REQ1_ADDR, REQ1_WDATA,
        input  REG_DATA_O, REG_DONE, REG_FAIL, READY,
        output REQ0_ACK, REQ0_FAIL, REQ0_RDATA,
        output REQ1_ACK, REQ1_FAIL, REQ1_RDATA,
        output REG_EN, REG_RW, REG_ADDR, REG_DATA_I, BUSY
    );
endinterface

// File: rtl/ulpi_rr_arb2.sv
// Two-port round-robin arbiter: one-hot grant, remembers the last port that
// was actually taken so simultaneous requests alternate.
module ulpi_rr_arb2 (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (take_i && (req_i != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Last-grant resets to port 1 so port 0 wins the first contest.
    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ulpi_reg_sched.sv
// ULPI register-access scheduler: arbitrates two requesters, retries on
// REG_FAIL with backoff. Optional per-attempt timeout: ULPI_SCHED_TIMEOUT_EN.
//
//  state     | meaning
//  S_IDLE    | waiting for READY and a valid request
//  S_ISSUE   | REG_EN high, waiting for REG_DONE / REG_FAIL
//  S_BACKOFF | REG_EN low between a REG_FAIL and its retry
//  S_RESP    | ACK pulse to the granted requester
module ulpi_reg_sched
    import ulpi_pkg::*;
#(
    parameter int MAX_RETRY   = MAX_RETRY_DEF,
    parameter int BACKOFF_CYC = BACKOFF_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            CLK_60M,
    input  logic            NRST_A_USB,
    ulpi_reg_sched_if.slave bus
);

    localparam int RTY_W = cnt_w(MAX_RETRY);
    localparam int BO_W  = cnt_w(BACKOFF_CYC);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
    localparam logic [BO_W-1:0]  BO_LOAD = BO_W'(BACKOFF_CYC - 1);

    sched_state_e     state_q;
    logic             grant_q;
    logic             rw_q;
    logic [5:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [RTY_W-1:0] retry_q;
    logic [BO_W-1:0]  bo_q;
    logic             reg_en_q;
    logic             busy_q;
    logic             ack0_q, ack1_q, fail0_q, fail1_q;
    logic [7:0]       rdata0_q, rdata1_q;

    logic [1:0] gnt;
    logic       end_ok, end_bad, retry_go, fin, tmo_hit;
    logic [7:0] fin_rdata;

    ulpi_rr_arb2 u_arb (
        .CLK_60M    (CLK_60M),
        .NRST_A_USB (NRST_A_USB),
        .req_i      ({bus.REQ1_VALID, bus.REQ0_VALID}),
        .take_i     ((state_q == S_IDLE) && bus.READY),
        .gnt_o      (gnt)
    );

`ifdef ULPI_SCHED_TIMEOUT_EN
    localparam int TMO_W = cnt_w(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q;
    assign tmo_hit = (tmo_q == '0);
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC != 0);
    assign tmo_hit    = 1'b0;
`endif

    // DONE wins over everything; READY loss aborts without retry.
    always_comb begin
        end_ok   = 1'b0;
        end_bad  = 1'b0;
        retry_go = 1'b0;
        if (state_q == S_ISSUE) begin
            if (bus.REG_DONE) begin
                end_ok = 1'b1;
            end else if (!bus.READY) begin
                end_bad = 1'b1;
            end else if (bus.REG_FAIL) begin
                if (retry_q < RTY_MAX) retry_go = 1'b1;
                else                   end_bad  = 1'b1;
            end else if (tmo_hit) begin
                end_bad = 1'b1;
            end
        end else if ((state_q == S_BACKOFF) && !bus.READY && (bo_q != '0)) begin
            end_bad = 1'b1;
        end
    end

    assign fin       = end_ok | end_bad;
    assign fin_rdata = rw_q ? wdata_q : (end_ok ? bus.REG_DATA_O : 8'h00);

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            retry_q  <= '0;
            bo_q     <= '0;
`ifdef ULPI_SCHED_TIMEOUT_EN
            tmo_q    <= '0;
`endif
            reg_en_q <= 1'b0;
            busy_q   <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            fail0_q  <= 1'b0;
            fail1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ack0_q  <= fin && !grant_q;
            ack1_q  <= fin && grant_q;
            fail0_q <= end_bad && !grant_q;
            fail1_q <= end_bad && grant_q;
            if (fin && !grant_q) rdata0_q <= fin_rdata;
            if (fin && grant_q)  rdata1_q <= fin_rdata;

            case (state_q)
                S_IDLE: begin
                    if (bus.READY && (gnt != 2'b00)) begin
                        grant_q  <= gnt[1];
                        rw_q     <= gnt[1] ? bus.REQ1_RW    : bus.REQ0_RW;
                        addr_q   <= gnt[1] ? bus.REQ1_ADDR  : bus.REQ0_ADDR;
                        wdata_q  <= gnt[1] ? bus.REQ1_WDATA : bus.REQ0_WDATA;
                        retry_q  <= '0;
`ifdef ULPI_SCHED_TIMEOUT_EN
                        tmo_q    <= TMO_LOAD;
`endif
                        reg_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (fin) begin
                        reg_en_q <= 1'b0;
                        state_q  <= S_RESP;
                    end else if (retry_go) begin
                        reg_en_q <= 1'b0;
                        retry_q  <= retry_q + 1'b1;
                        bo_q     <= BO_LOAD;
                        state_q  <= S_BACKOFF;
                    end
`ifdef ULPI_SCHED_TIMEOUT_EN
                    else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
`endif
                end
                S_BACKOFF: begin
                    if (fin) begin
                        state_q <= S_RESP;
                    end else if (bo_q != '0) begin
                        bo_q <= bo_q - 1'b1;
                    end else if (bus.READY) begin
`ifdef ULPI_SCHED_TIMEOUT_EN
                        tmo_q    <= TMO_LOAD;
`endif
                        reg_en_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.REG_EN     = reg_en_q;
    assign bus.REG_RW     = rw_q;
    assign bus.REG_ADDR   = addr_q;
    assign bus.REG_DATA_I = wdata_q;
    assign bus.BUSY       = busy_q;
    assign bus.REQ0_ACK   = ack0_q;
    assign bus.REQ0_FAIL  = fail0_q;
    assign bus.REQ0_RDATA = rdata0_q;
    assign bus.REQ1_ACK   = ack1_q;
    assign bus.REQ1_FAIL  = fail1_q;
    assign bus.REQ1_RDATA = rdata1_q;

endmodule

// File: tb/tb_ulpi_reg_sched.sv
// Directed bench for ulpi_reg_sched (default parameters); the timeout step is
// compiled only when ULPI_SCHED_TIMEOUT_EN is defined.
module tb_ulpi_reg_sched;
    import ulpi_pkg::*;

    logic CLK_60M = 1'b0;
    logic NRST_A_USB;
    int   errors = 0;
    int   checks = 0;

    ulpi_reg_sched_if u ();

    ulpi_reg_sched dut (
        .CLK_60M    (CLK_60M),
        .NRST_A_USB (NRST_A_USB),
        .bus        (u)
    );

    always #5 CLK_60M = ~CLK_60M;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_reg_en"},  u.REG_EN, 0);
        chk({pfx, "_reg_rw"},  u.REG_RW, 0);
        chk({pfx, "_reg_addr"}, u.REG_ADDR, 0);
        chk({pfx, "_reg_di"},  u.REG_DATA_I, 0);
        chk({pfx, "_ack0"},    u.REQ0_ACK, 0);
        chk({pfx, "_ack1"},    u.REQ1_ACK, 0);
        chk({pfx, "_fail0"},   u.REQ0_FAIL, 0);
        chk({pfx, "_fail1"},   u.REQ1_FAIL, 0);
        chk({pfx, "_rdata0"},  u.REQ0_RDATA, 0);
        chk({pfx, "_rdata1"},  u.REQ1_RDATA, 0);
        chk({pfx, "_busy"},    u.BUSY, 0);
    endtask

    // PHY model: wait for the strobe, hold it lat cycles, then answer.
    // Returns at the negedge after the answer was sampled (ACK visible there).
    task automatic serve(input int lat, input bit fail_it, input logic [7:0] dout,
                         input logic [5:0] exp_addr, input logic exp_rw,
                         input logic [7:0] exp_di, output int gap);
        gap = 0;
        @(negedge CLK_60M);
        while (u.REG_EN !== 1'b1 && gap < 40) begin
            gap++;
            @(negedge CLK_60M);
        end
        chk("en_rise", u.REG_EN, 1);
        chk("reg_addr", u.REG_ADDR, exp_addr);
        chk("reg_rw", u.REG_RW, exp_rw);
        chk("reg_data_i", u.REG_DATA_I, exp_di);
        for (int i = 1; i < lat; i++) begin
            @(negedge CLK_60M);
            chk("en_hold", u.REG_EN, 1);
            chk("addr_hold", u.REG_ADDR, exp_addr);
        end
        u.REG_DATA_O = dout;
        if (fail_it) u.REG_FAIL = 1'b1;
        else         u.REG_DONE = 1'b1;
        @(negedge CLK_60M);
        chk("en_drop", u.REG_EN, 0);
        u.REG_DONE = 1'b0;
        u.REG_FAIL = 1'b0;
    endtask

    initial begin
        int gap;
        int n;

        NRST_A_USB   = 1'b0;
        u.REQ0_VALID = 0; u.REQ0_RW = 0; u.REQ0_ADDR = 0; u.REQ0_WDATA = 0;
        u.REQ1_VALID = 0; u.REQ1_RW = 0; u.REQ1_ADDR = 0; u.REQ1_WDATA = 0;
        u.REG_DATA_O = 0; u.REG_DONE = 0; u.REG_FAIL = 0; u.READY = 0;
        repeat (2) @(negedge CLK_60M);
        chk_reset("rst");
        NRST_A_USB = 1'b1;
        u.READY    = 1'b1;

        // Simultaneous reads: port 0 first after reset.
        u.REQ0_VALID = 1; u.REQ0_RW = 0; u.REQ0_ADDR = 6'h0A;
        u.REQ1_VALID = 1; u.REQ1_RW = 0; u.REQ1_ADDR = 6'h0B;
        serve(2, 0, 8'hA5, 6'h0A, 0, 8'h00, gap);
        chk("pairA_gap", gap, 0);
        chk("pairA_ack0", u.REQ0_ACK, 1);
        chk("pairA_ack1", u.REQ1_ACK, 0);
        chk("pairA_fail0", u.REQ0_FAIL, 0);
        chk("pairA_rdata0", u.REQ0_RDATA, 8'hA5);
        chk("pairA_busy", u.BUSY, 1);
        // Port 0 keeps VALID high with a new request: second contest goes to port 1.
        u.REQ0_ADDR = 6'h0C;
        serve(1, 0, 8'h3C, 6'h0B, 0, 8'h00, gap);
        chk("pairB_gap", gap, 1);
        chk("pairB_ack1", u.REQ1_ACK, 1);
        chk("pairB_ack0", u.REQ0_ACK, 0);
        chk("pairB_rdata1", u.REQ1_RDATA, 8'h3C);
        chk("pairB_rdata0_hold", u.REQ0_RDATA, 8'hA5);
        u.REQ1_VALID = 0;
        serve(1, 0, 8'h5A, 6'h0C, 0, 8'h00, gap);
        chk("pairB2_ack0", u.REQ0_ACK, 1);
        chk("pairB2_rdata0", u.REQ0_RDATA, 8'h5A);
        u.REQ0_VALID = 0;
        @(negedge CLK_60M);
        chk("idle_busy", u.BUSY, 0);
        chk("ack_pulse", u.REQ0_ACK, 0);

        // Write FUNC_CTRL, DONE after 3 strobe cycles.
        u.REQ0_VALID = 1; u.REQ0_RW = 1; u.REQ0_ADDR = 6'h04; u.REQ0_WDATA = 8'h66;
        serve(3, 0, 8'h00, 6'h04, 1, 8'h66, gap);
        chk("wr_ack0", u.REQ0_ACK, 1);
        chk("wr_fail0", u.REQ0_FAIL, 0);
        chk("wr_ack1", u.REQ1_ACK, 0);
        chk("wr_rdata0", u.REQ0_RDATA, 8'h66);
        u.REQ0_VALID = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_60M);
            chk("wr_single_burst", u.REG_EN, 0);
        end

        // Three FAILs then DONE on port 1.
        u.REQ1_VALID = 1; u.REQ1_RW = 0; u.REQ1_ADDR = 6'h16; u.REQ1_WDATA = 0;
        for (int a = 0; a < 4; a++) begin
            serve(2, (a < 3), 8'hC3, 6'h16, 0, 8'h00, gap);
            if (a == 0) chk("rty_first_gap", gap, 0);
            else        chk("rty_backoff_low", gap + 1, 4);
            if (a < 3)  chk("rty_no_ack", u.REQ1_ACK, 0);
        end
        chk("rty_ack1", u.REQ1_ACK, 1);
        chk("rty_fail1", u.REQ1_FAIL, 0);
        chk("rty_rdata1", u.REQ1_RDATA, 8'hC3);
        u.REQ1_VALID = 0;

        // Four FAILs on a port-0 write: reported as failed.
        u.REQ0_VALID = 1; u.REQ0_RW = 1; u.REQ0_ADDR = 6'h05; u.REQ0_WDATA = 8'h11;
        for (int a = 0; a < 4; a++) begin
            serve(1, 1, 8'h00, 6'h05, 1, 8'h11, gap);
            if (a < 3) chk("xf_no_ack", u.REQ0_ACK, 0);
        end
        chk("xf_ack0", u.REQ0_ACK, 1);
        chk("xf_fail0", u.REQ0_FAIL, 1);
        chk("xf_rdata0", u.REQ0_RDATA, 8'h11);
        u.REQ0_VALID = 0;

        // READY drops in the second strobe cycle.
        @(negedge CLK_60M);
        u.REQ0_VALID = 1; u.REQ0_RW = 0; u.REQ0_ADDR = 6'h07; u.REQ0_WDATA = 0;
        @(negedge CLK_60M);
        chk("ab_en1", u.REG_EN, 1);
        @(negedge CLK_60M);
        chk("ab_en2", u.REG_EN, 1);
        u.READY = 0;
        @(negedge CLK_60M);
        chk("ab_en_drop", u.REG_EN, 0);
        chk("ab_ack0", u.REQ0_ACK, 1);
        chk("ab_fail0", u.REQ0_FAIL, 1);
        chk("ab_rdata0", u.REQ0_RDATA, 8'h00);
        u.REQ0_VALID = 0;
        u.REQ1_VALID = 1; u.REQ1_RW = 0; u.REQ1_ADDR = 6'h0A;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_60M);
            chk("nr_busy", u.BUSY, 0);
            chk("nr_en", u.REG_EN, 0);
        end
        u.READY = 1;
        serve(1, 0, 8'h77, 6'h0A, 0, 8'h00, gap);
        chk("nr_late_ack1", u.REQ1_ACK, 1);
        chk("nr_late_rdata1", u.REQ1_RDATA, 8'h77);
        u.REQ1_VALID = 0;

`ifdef ULPI_SCHED_TIMEOUT_EN
        @(negedge CLK_60M);
        u.REQ1_VALID = 1; u.REQ1_RW = 0; u.REQ1_ADDR = 6'h16;
        n   = 0;
        gap = 0;
        @(negedge CLK_60M);
        while (u.REG_EN !== 1'b1 && gap < 10) begin
            gap++;
            @(negedge CLK_60M);
        end
        while (u.REG_EN === 1'b1 && n < 400) begin
            n++;
            @(negedge CLK_60M);
        end
        chk("tmo_len", n, 255);
        chk("tmo_ack1", u.REQ1_ACK, 1);
        chk("tmo_fail1", u.REQ1_FAIL, 1);
        u.REQ1_VALID = 0;
`endif

        // Reset in the middle of a strobe: request dropped, no ACK.
        @(negedge CLK_60M);
        u.REQ0_VALID = 1; u.REQ0_RW = 1; u.REQ0_ADDR = 6'h0A; u.REQ0_WDATA = 8'h5F;
        @(negedge CLK_60M);
        chk("mr_en", u.REG_EN, 1);
        @(negedge CLK_60M);
        NRST_A_USB   = 1'b0;
        u.REQ0_VALID = 0;
        #2;
        chk_reset("mr");
        @(negedge CLK_60M);
        NRST_A_USB = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK_60M);
            if (u.REQ0_ACK !== 1'b0 || u.REG_EN !== 1'b0) n++;
        end
        chk("mr_no_ack", n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
